// File: rtl/msk_nco_ctrl.sv
// Sequencer for the MSK modulator NCO: starts the dds, waits for out_valid, then maps
// one accepted data bit per symbol onto a +/-DEV frequency word held for SPS samples.
module msk_nco_ctrl #(
  parameter int             PW       = 25,
  parameter logic [PW-1:0]  CARRIER  = 25'h0600000,
  parameter logic [PW-1:0]  DEV      = 25'h0040000,
  parameter int             SPS      = 16,
  parameter int             RST_CYC  = 7,
  parameter int             VALID_TO = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          bit_valid,
  input  logic          bit_data,
  output logic          bit_ready,
  output logic          nco_reset_n,
  output logic          nco_clken,
  output logic [PW-1:0] nco_phi_inc,
  output logic [PW-1:0] nco_freq_mod,
  input  logic          nco_out_valid,
  output logic          sym_strobe,
  output logic          busy,
  output logic          underrun
);

  localparam int CMAX_A = (VALID_TO > SPS) ? VALID_TO : SPS;
  localparam int CMAX   = (CMAX_A > RST_CYC) ? CMAX_A : RST_CYC;
  localparam int CW     = $clog2(CMAX + 1);

  localparam logic [CW-1:0] SYM_LAST = CW'(SPS - 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] VTO_LAST = CW'(VALID_TO - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NRST  = 2'd1,
    S_WAITV = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic                 r_ready;
  logic                 r_rstn;
  logic                 r_clken;
  logic signed [PW-1:0] r_freq;
  logic                 r_strobe;
  logic                 r_busy;
  logic                 r_underrun;

  logic                 w_accept;
  logic                 w_sym_end;

  // Bit-to-frequency mapping; the negative word wraps modulo 2^PW.
  function automatic logic signed [PW-1:0] sym_word(input logic b);
    logic signed [PW-1:0] dev_s;
    dev_s = $signed(DEV);
    return b ? dev_s : -dev_s;
  endfunction

  assign w_accept  = bit_valid & r_ready;
  assign w_sym_end = (r_cnt == SYM_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_ready    <= 1'b0;
      r_rstn     <= 1'b0;
      r_clken    <= 1'b0;
      r_freq     <= '0;
      r_strobe   <= 1'b0;
      r_busy     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b0;
          r_freq  <= '0;
          if (enable) begin
            r_state    <= S_NRST;
            r_cnt      <= '0;
            r_clken    <= 1'b1;
            r_rstn     <= 1'b0;
            r_busy     <= 1'b1;
            r_underrun <= 1'b0;
          end
        end

        S_NRST: begin
          if (!enable) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_clken <= 1'b0;
            r_rstn  <= 1'b0;
            r_freq  <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == RST_LAST) begin
            r_state <= S_WAITV;
            r_cnt   <= '0;
            r_rstn  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // Timeout on out_valid silently re-pulses the dds reset.
        S_WAITV: begin
          if (!enable) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_clken <= 1'b0;
            r_rstn  <= 1'b0;
            r_freq  <= '0;
            r_busy  <= 1'b0;
          end else if (nco_out_valid) begin
            r_state <= S_RUN;
            r_cnt   <= SYM_LAST;
            r_ready <= 1'b1;
          end else if (r_cnt == VTO_LAST) begin
            r_state <= S_NRST;
            r_cnt   <= '0;
            r_rstn  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // Ready low at the boundary means enable was dropped: finish and stop.
        S_RUN: begin
          if (w_sym_end) begin
            r_cnt   <= '0;
            r_ready <= 1'b0;
            if (w_accept) begin
              r_freq   <= sym_word(bit_data);
              r_strobe <= 1'b1;
            end else if (!r_ready) begin
              r_state <= S_IDLE;
              r_clken <= 1'b0;
              r_rstn  <= 1'b0;
              r_freq  <= '0;
              r_busy  <= 1'b0;
            end else begin
              r_freq     <= '0;
              r_underrun <= 1'b1;
              r_strobe   <= 1'b1;
            end
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_ready <= ((r_cnt + 1'b1) == SYM_LAST) & enable;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_ready <= 1'b0;
          r_clken <= 1'b0;
          r_rstn  <= 1'b0;
          r_freq  <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bit_ready    = r_ready;
  assign nco_reset_n  = r_rstn;
  assign nco_clken    = r_clken;
  assign nco_phi_inc  = CARRIER;
  assign nco_freq_mod = r_freq;
  assign sym_strobe   = r_strobe;
  assign busy         = r_busy;
  assign underrun     = r_underrun;

endmodule
